water_level_emulator: RTL
=========================

WATER_LEVEL_EMULATOR -- requirements
Module: water_level_emulator

Interface
REQ-001 Parameter: STEP_CYCLES, default 4, clock cycles per one-level step (legal range 1..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 cmd_valid  input  1  target-level command present.
REQ-005 cmd_level  input  3  commanded target level, 0..7.
REQ-006 cmd_ready  output  1  high when a command can be accepted.
REQ-007 sensor_out  output  8  active-low one-hot sensor pattern for the current level.
REQ-008 cur_level  output  3  current emulated level.
REQ-009 busy  output  1  high while a command is in progress.
REQ-010 done  output  1  one-cycle pulse when the target level is reached.

Function
REQ-011 The block SHALL drive the sensor pattern that the level encoder consumes: sensor_out[k] = 0 for k == cur_level, all other bits 1 (level 0 = 8'hFE, 1 = 8'hFD, 2 = 8'hFB, 3 = 8'hF7, 7 = 8'h7F).
REQ-012 sensor_out SHALL be a pure decode of the registered cur_level, with no extra cycle of delay.
REQ-013 The state machine SHALL have exactly three states: IDLE, RAMP and DONE.
REQ-014 cmd_ready SHALL equal (state == IDLE); busy SHALL equal (state != IDLE); done SHALL equal (state == DONE).
REQ-015 Handshake: a command SHALL be accepted on a rising edge with cmd_valid && cmd_ready; the block SHALL latch cmd_level as the target.
REQ-016 cmd_valid outside IDLE SHALL be ignored without error, and the command SHALL NOT be queued.
REQ-017 On acceptance with target == cur_level: IDLE SHALL go to DONE, and cur_level SHALL NOT change.
REQ-018 On acceptance with target != cur_level: IDLE SHALL go to RAMP, and the step counter SHALL be cleared to 0.
REQ-019 In RAMP, each edge SHALL do the following:
  - if counter == STEP_CYCLES-1: counter returns to 0, and cur_level moves one toward the target (+1 if target > cur_level, else -1);
  - otherwise: counter increments.
REQ-020 When a step makes cur_level equal the target, RAMP SHALL go to DONE on that same edge.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-022 Latency for an accept at edge N with distance d = |target - cur_level|:
  - d > 0: level steps at edges N + k*STEP_CYCLES (k = 1..d); done is high in the cycle after edge N + d*STEP_CYCLES.
  - d = 0: done is high in the cycle after edge N.
REQ-023 cur_level SHALL never leave 0..7 and SHALL never wrap; it changes by at most 1 per step.
REQ-024 With STEP_CYCLES = 1, the block SHALL step once per cycle.
REQ-025 The step counter SHALL be 8 bits wide.

Reset
REQ-026 While rst is high, and immediately on its assertion (including mid-RAMP), the block SHALL force:
  - state = IDLE, counter = 0, target = 0, cur_level = 0;
  - sensor_out = 8'hFE, cmd_ready = 1, busy = 0, done = 0.
REQ-027 No command SHALL be accepted on any edge where rst is high.
REQ-028 After rst deasserts, the first acceptable edge SHALL be the next rising edge with cmd_valid high.

Verification (STEP_CYCLES = 4)
REQ-029 Reset: assert rst -> sensor_out = 8'hFE, cur_level = 0, cmd_ready = 1, busy = 0, done = 0.
REQ-030 From level 0, cmd_level = 3 accepted at edge N:
  - sensor_out goes 8'hFD at N+4, 8'hFB at N+8, 8'hF7 at N+12;
  - done pulses exactly one cycle after N+12;
  - busy is high from N through the done cycle.
REQ-031 From level 3, cmd_level = 1 -> sensor_out goes 8'hFB at N+4, then 8'hFD at N+8; done follows, confirming downward ramp.
REQ-032 Command while busy and same-level command:
  - During the 0->3 ramp, cmd_valid with cmd_level = 7 -> ignored; the final level is 3.
  - Then cmd_level = 3 -> done the next cycle, sensor_out unchanged.
REQ-033 Reset mid-ramp: during the 0->5 ramp at level 2, assert rst asynchronously -> sensor_out = 8'hFE before the next clock edge, and busy = 0.
REQ-034 Full span: 0->7 reaches 8'h7F after 28 cycles; then 7->0 returns to 8'hFE after 28 cycles; every intermediate pattern is one-hot-low.

Source files
------------

// File: rtl/water_level_emulator.sv
// Water level emulator: ramps an emulated tank level toward a commanded target,
// one level every STEP_CYCLES clocks, and presents the level as the active-low
// one-hot sensor pattern that the downstream level encoder expects.
module water_level_emulator #(
   parameter int STEP_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [2:0] cmd_level,
   output logic       cmd_ready,
   output logic [7:0] sensor_out,
   output logic [2:0] cur_level,
   output logic       busy,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RAMP = 2'd1,
      DONE = 2'd2
   } state_t;

   // Last counter value before a level step is taken.
   localparam logic [7:0] STEP_LAST = 8'(STEP_CYCLES - 1);

   state_t     state_r;
   state_t     state_s;
   logic [7:0] cnt_r;
   logic [7:0] cnt_s;
   logic [2:0] target_r;
   logic [2:0] target_s;
   logic [2:0] level_r;
   logic [2:0] level_s;
   logic [2:0] step_level_s;

   // Active-low one-hot decode of a level: the bit at the level position reads 0.
   function automatic logic [7:0] level_to_sensor(input logic [2:0] lvl);
      level_to_sensor = ~(8'd1 << lvl);
   endfunction

   // State and datapath registers; reset forces the block back to an idle tank at level 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= IDLE;
         cnt_r    <= 8'd0;
         target_r <= 3'd0;
         level_r  <= 3'd0;
      end else begin
         state_r  <= state_s;
         cnt_r    <= cnt_s;
         target_r <= target_s;
         level_r  <= level_s;
      end
   end

   // Next-state and next-datapath logic: accept in IDLE, step in RAMP, single-cycle DONE.
   always_comb begin
      state_s  = state_r;
      cnt_s    = cnt_r;
      target_s = target_r;
      level_s  = level_r;
      // Only used in RAMP, where target differs from level, so this never wraps.
      if (target_r > level_r) begin
         step_level_s = level_r + 3'd1;
      end else begin
         step_level_s = level_r - 3'd1;
      end
      case (state_r)
         IDLE: begin
            if (cmd_valid) begin
               target_s = cmd_level;
               cnt_s    = 8'd0;
               if (cmd_level == level_r) begin
                  state_s = DONE;
               end else begin
                  state_s = RAMP;
               end
            end else begin
               state_s = IDLE;
            end
         end
         RAMP: begin
            if (cnt_r == STEP_LAST) begin
               cnt_s   = 8'd0;
               level_s = step_level_s;
               if (step_level_s == target_r) begin
                  state_s = DONE;
               end else begin
                  state_s = RAMP;
               end
            end else begin
               cnt_s = cnt_r + 8'd1;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 8'd0;
         end
      endcase
   end

   // Outputs decoded directly from the registered state and level, no extra delay.
   always_comb begin
      cur_level  = level_r;
      sensor_out = level_to_sensor(level_r);
      case (state_r)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            done      = 1'b0;
         end
         RAMP: begin
            cmd_ready = 1'b0;
            busy      = 1'b1;
            done      = 1'b0;
         end
         DONE: begin
            cmd_ready = 1'b0;
            busy      = 1'b1;
            done      = 1'b1;
         end
         default: begin
            cmd_ready = 1'b0;
            busy      = 1'b1;
            done      = 1'b0;
         end
      endcase
   end

endmodule
